mps_intl_latch: RTL
===================

MPS_INTL_LATCH -- requirements
Module: mps_intl_latch

Interface
REQ-001 SHALL have parameter DI_MASK, default 16'h01F1, selecting which i_ext_di bits are interlock inputs (bits 0, 4..8).
REQ-002 SHALL have parameter DEB_W, default 16, giving the debounce counter width.
REQ-003 SHALL have one clock and a synchronous, active-low reset: i_clk and i_rst.
REQ-004 SHALL have these ports (name, direction, width, meaning):
- i_clk  in  1  system clock
- i_rst  in  1  synchronous active-low reset
- i_analog_intl  in  18  on-chip analog comparator interlocks, synchronous, active-high
- i_ext_di  in  16  external digital inputs, asynchronous
- i_pwm_fault  in  4  gate-driver faults, synchronous, active-high
- i_intl_OC  in  1  overcurrent interlock, synchronous, active-high
- i_intl_clr  in  1  single-cycle clear request from the AXI register block
- i_deb_len  in  DEB_W  external DI debounce length in cycles
- o_intl_flag  out  1  interlock active; drives the system FSM i_intl_flag
- o_intl_status  out  29  latched sources: [17:0] analog, [23:18] masked DI (in ascending bit order), [27:24] pwm, [28] OC
- o_first_fault  out  5  index of the first latched source
- o_first_valid  out  1  o_first_fault is meaningful
- o_clr_reject  out  1  one-cycle pulse when a clear is refused
- o_state  out  2  FSM state, for readback

Function
REQ-005 i_ext_di SHALL pass through a 2-FF synchronizer before debounce.
REQ-006 Each masked DI SHALL have its own DEB_W counter:
- increments while the synced bit is 1, saturating at i_deb_len
- clears to 0 when the synced bit is 0
- the bit is qualified while count == i_deb_len
- i_deb_len = 0 SHALL be treated as 1
REQ-007 Analog, pwm and OC inputs SHALL be qualified the same cycle they are sampled, with no synchronizer and no debounce.
REQ-008 FSM states: NORMAL = 2'd0, TRIP = 2'd1, CLEAR = 2'd2; encoding 2'd3 SHALL return to NORMAL.
REQ-009 In NORMAL, any qualified source SHALL move the FSM to TRIP on the next edge and OR the qualified vector into o_intl_status.
REQ-010 In TRIP, newly qualified sources SHALL keep being ORed into o_intl_status; latched bits SHALL NOT clear while in TRIP.
REQ-011 In TRIP, i_intl_clr with zero qualified sources SHALL move the FSM to CLEAR.
REQ-012 In TRIP, i_intl_clr with any qualified source active SHALL keep the FSM in TRIP and pulse o_clr_reject for one cycle.
REQ-013 CLEAR SHALL last exactly one cycle:
- zero o_intl_status, o_first_fault, o_first_valid and all debounce counters
- then go to NORMAL
REQ-014 A source qualifying during the CLEAR cycle SHALL be ignored that cycle and re-detected from NORMAL.
REQ-015 o_intl_flag SHALL be registered and equal (state != NORMAL).
- latency from a synchronous source input to o_intl_flag: 1 cycle
- latency from a DI input to o_intl_flag: 2 + i_deb_len + 1 cycles
REQ-016 i_intl_clr in NORMAL or CLEAR SHALL be ignored and SHALL NOT pulse o_clr_reject.
REQ-017 An asserted i_intl_clr SHALL be sampled each cycle as a level; no edge detection.

Reset
REQ-018 On i_rst = 0 at a clock edge, these SHALL be zero: state (NORMAL), o_intl_flag, o_intl_status, o_first_fault, o_first_valid, o_clr_reject, synchronizers and all counters.
REQ-019 Reset asserted while in TRIP SHALL discard all latched data with no clear handshake.

Configuration
REQ-020 With macro MPS_INTL_FIRST_FAULT_EN defined, first-fault capture SHALL operate as follows:
- on the NORMAL->TRIP edge, capture the lowest qualified index into o_first_fault and set o_first_valid
- hold both until CLEAR or reset
- on simultaneous sources, the lowest index wins
REQ-021 Without MPS_INTL_FIRST_FAULT_EN, o_first_fault and o_first_valid SHALL be constant 0 and no capture logic SHALL be built.

Structure
REQ-022 Package mps_intl_pkg SHALL hold:
- the state enum
- source index constants: ANA_BASE = 0, DI_BASE = 18, PWM_BASE = 24, OC_IDX = 28
- total source count 29
- DI_MASK default
REQ-023 Per-bit DI synchronizer plus debounce SHALL be sub-module mps_di_debounce, instantiated 6 times via generate.

Verification
REQ-024 Scenario: i_analog_intl[5] pulses 1 cycle -> o_intl_flag=1 one cycle later and stays; o_intl_status=29'h20; o_first_fault=5.
REQ-025 Scenario: i_deb_len=10, i_ext_di[4] high 9 cycles -> no trip; high 13 cycles -> TRIP; o_intl_status[19]=1.
REQ-026 Scenario: i_pwm_fault[1] and i_intl_OC rise in the same cycle -> o_intl_status bits 25 and 28 set; o_first_fault=25.
REQ-027 Scenario: in TRIP, with i_intl_OC still 1, pulse i_intl_clr -> o_clr_reject=1 for 1 cycle; state stays 1.
REQ-028 Scenario: in TRIP, with all sources 0, pulse i_intl_clr -> state 2 for 1 cycle, then 0; o_intl_status=0; o_intl_flag=0.
REQ-029 Scenario: i_rst=0 for 1 cycle while in TRIP -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/mps_intl_pkg.sv
// Shared types and constants for the MPS interlock latch: state encoding,
// source index map and small constant helpers.
package mps_intl_pkg;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_TRIP   = 2'd1,
    ST_CLEAR  = 2'd2
  } intl_state_e;

  localparam int ANA_BASE = 0;
  localparam int ANA_N    = 18;
  localparam int DI_BASE  = 18;
  localparam int DI_N     = 6;
  localparam int PWM_BASE = 24;
  localparam int PWM_N    = 4;
  localparam int OC_IDX   = 28;
  localparam int SRC_N    = 29;

  localparam logic [15:0] DI_MASK_DEFAULT = 16'h01F1;

  // Bit position of the k-th set bit of the DI mask, counting from bit 0.
  function automatic int di_bit_pos(input logic [15:0] mask, input int k);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int i = 0; i < 16; i++) begin
      if (mask[i]) begin
        if (n == k) pos = i;
        n++;
      end
    end
    return pos;
  endfunction

  // Lowest set index of a source vector; simultaneous sources resolve low.
  function automatic logic [4:0] lowest_index(input logic [SRC_N-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = SRC_N - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mps_di_debounce.sv
// One external digital interlock input: 2-FF synchronizer followed by a
// saturating debounce counter. A zero debounce length behaves as one.
module mps_di_debounce #(
  parameter int DEB_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             din,
  input  logic [DEB_W-1:0] deb_len,
  output logic             qual
);

  logic             sync1;
  logic             sync2;
  logic [DEB_W-1:0] cnt;
  logic [DEB_W-1:0] len_eff;

  assign len_eff = (deb_len == '0) ? DEB_W'(1) : deb_len;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (clr || !sync2) begin
        cnt <= '0;
      end else if (cnt < len_eff) begin
        cnt <= cnt + DEB_W'(1);
      end else begin
        // Also pulls the count back if the length was lowered mid-count.
        cnt <= len_eff;
      end
    end
  end

  assign qual = (cnt == len_eff);

endmodule

// File: rtl/mps_intl_latch.sv
// Interlock latch: qualifies analog/DI/pwm/OC sources, latches them in TRIP
// until a clean clear. First-fault capture is built only with MPS_INTL_FIRST_FAULT_EN.
module mps_intl_latch
  import mps_intl_pkg::*;
#(
  parameter logic [15:0] DI_MASK = DI_MASK_DEFAULT,
  parameter int          DEB_W   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [ANA_N-1:0]     i_analog_intl,
  input  logic [15:0]          i_ext_di,
  input  logic [PWM_N-1:0]     i_pwm_fault,
  input  logic                 i_intl_OC,
  input  logic                 i_intl_clr,
  input  logic [DEB_W-1:0]     i_deb_len,
  output logic                 o_intl_flag,
  output logic [SRC_N-1:0]     o_intl_status,
  output logic [4:0]           o_first_fault,
  output logic                 o_first_valid,
  output logic                 o_clr_reject,
  output logic [1:0]           o_state
);

  intl_state_e      state;
  logic [DI_N-1:0]  di_qual;
  logic [SRC_N-1:0] qual;
  logic             deb_clr;
  logic             unused_di;

  assign deb_clr   = (state == ST_CLEAR);
  assign unused_di = ^(i_ext_di & ~DI_MASK);

  // Masked DI bits are packed densely into status[23:18] in ascending order.
  for (genvar k = 0; k < DI_N; k++) begin : g_di
    localparam int BIT = di_bit_pos(DI_MASK, k);
    mps_di_debounce #(
      .DEB_W (DEB_W)
    ) u_deb (
      .clk     (i_clk),
      .rst_n   (i_rst),
      .clr     (deb_clr),
      .din     (i_ext_di[BIT]),
      .deb_len (i_deb_len),
      .qual    (di_qual[k])
    );
  end

  assign qual = {i_intl_OC, i_pwm_fault, di_qual, i_analog_intl};

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= ST_NORMAL;
      o_intl_flag   <= 1'b0;
      o_intl_status <= '0;
      o_clr_reject  <= 1'b0;
    end else begin
      o_clr_reject <= 1'b0;
      case (state)
        ST_NORMAL: begin
          if (|qual) begin
            state         <= ST_TRIP;
            o_intl_flag   <= 1'b1;
            o_intl_status <= o_intl_status | qual;
          end
        end
        ST_TRIP: begin
          o_intl_status <= o_intl_status | qual;
          if (i_intl_clr) begin
            if (|qual) begin
              o_clr_reject <= 1'b1;
            end else begin
              state <= ST_CLEAR;
            end
          end
        end
        ST_CLEAR: begin
          // Sources seen in this cycle are dropped and re-detected from NORMAL.
          state         <= ST_NORMAL;
          o_intl_flag   <= 1'b0;
          o_intl_status <= '0;
        end
        default: begin
          state       <= ST_NORMAL;
          o_intl_flag <= 1'b0;
        end
      endcase
    end
  end

`ifdef MPS_INTL_FIRST_FAULT_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_first_fault <= '0;
      o_first_valid <= 1'b0;
    end else if (state == ST_CLEAR) begin
      o_first_fault <= '0;
      o_first_valid <= 1'b0;
    end else if (state == ST_NORMAL && (|qual)) begin
      o_first_fault <= lowest_index(qual);
      o_first_valid <= 1'b1;
    end
  end
`else
  assign o_first_fault = '0;
  assign o_first_valid = 1'b0;
`endif

  assign o_state = state;

endmodule
